// File: rtl/rstctl_pkg.sv
// Shared types and defaults for the RST/PRESET driver (rst_preset_ctrl) and its synchronizer.
package rstctl_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    HOLD   = 2'd1,
    PRESET = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_HOLD_CYCLES   = 8;
  localparam int unsigned DEF_PRESET_CYCLES = 4;
  localparam int unsigned DEF_WDOG_CYCLES   = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-deassertion synchronizer: async clear, ones shifted in after release.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chain <= '0;
    else      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_preset_ctrl.sv
// Drives glitch-free active-low RST/PRESET to a clock domain's flop banks.
// Optional watchdog auto-reset is compiled in with `define RSTCTRL_WDOG_EN.
module rst_preset_ctrl
  import rstctl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter int unsigned WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_RST_REQ,
  input  logic PRESET_REQ,
  input  logic WDOG_KICK,
  output logic RST_N_OUT,
  output logic PRESET_N_OUT,
  output logic READY,
  output logic BUSY,
  output logic WDOG_FIRED
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, PRESET_CYCLES) + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_c;
  logic             wdog_to_c;
  logic             rst_n_d, preset_n_d, ready_d, busy_d, fired_d;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .CLK      (CLK),
    .RST      (RST),
    .sync_out (sync_c)
  );

`ifdef RSTCTRL_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts un-kicked RUN cycles; held clear outside RUN so every RUN entry starts at 0.
  always_comb begin
    wd_d      = '0;
    wdog_to_c = 1'b0;
    if (state_q == RUN) begin
      if (WDOG_KICK)                            wd_d = '0;
      else if (wd_q == WD_W'(WDOG_CYCLES - 1))  wdog_to_c = 1'b1;
      else                                      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
  logic unused_wdog_kick;
  assign unused_wdog_kick = WDOG_KICK;
  assign wdog_to_c        = 1'b0;
`endif

  // Next state; reset requests always win over preset, matching flop RST-over-PRESET priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ASSERT: begin
        if (sync_c) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (SW_RST_REQ) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESET: begin
        if (SW_RST_REQ) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(PRESET_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (SW_RST_REQ || wdog_to_c) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (PRESET_REQ) begin
          state_d = PRESET;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase

    rst_n_d    = (state_d == RUN) || (state_d == PRESET);
    preset_n_d = (state_d != PRESET);
    ready_d    = (state_d == RUN);
    busy_d     = (state_d != RUN);
    fired_d    = WDOG_FIRED | wdog_to_c;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ASSERT;
      cnt_q        <= '0;
      RST_N_OUT    <= 1'b0;
      PRESET_N_OUT <= 1'b1;
      READY        <= 1'b0;
      BUSY         <= 1'b1;
      WDOG_FIRED   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      RST_N_OUT    <= rst_n_d;
      PRESET_N_OUT <= preset_n_d;
      READY        <= ready_d;
      BUSY         <= busy_d;
      WDOG_FIRED   <= fired_d;
    end
  end

endmodule

// File: tb/tb_rst_preset_ctrl.sv
// Scoreboard bench for rst_preset_ctrl: remaining-cycle reference model, directed then random stimulus.
module tb_rst_preset_ctrl;

  localparam int S = 2;
  localparam int H = 8;
  localparam int P = 4;
  localparam int W = 16;
`ifdef RSTCTRL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW_RST_REQ = 1'b0;
  logic PRESET_REQ = 1'b0;
  logic WDOG_KICK = 1'b0;
  logic RST_N_OUT, PRESET_N_OUT, READY, BUSY, WDOG_FIRED;

  rst_preset_ctrl #(
    .SYNC_STAGES   (S),
    .HOLD_CYCLES   (H),
    .PRESET_CYCLES (P),
    .WDOG_CYCLES   (W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SW_RST_REQ   (SW_RST_REQ),
    .PRESET_REQ   (PRESET_REQ),
    .WDOG_KICK    (WDOG_KICK),
    .RST_N_OUT    (RST_N_OUT),
    .PRESET_N_OUT (PRESET_N_OUT),
    .READY        (READY),
    .BUSY         (BUSY),
    .WDOG_FIRED   (WDOG_FIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst_n;
    logic preset_n;
    logic ready;
    logic busy;
    logic fired;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model: r = edges until RST_N_OUT rises (r<=H means holding), pre = preset cycles left,
  // wd = un-kicked RUN cycles so far.
  int r     = S + 1 + H;
  int pre   = 0;
  int wd    = 0;
  bit fired = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.rst_n    = (r == 0);
    e.preset_n = (pre == 0);
    e.ready    = (r == 0) && (pre == 0);
    e.busy     = !((r == 0) && (pre == 0));
    e.fired    = fired;
    return e;
  endfunction

  task automatic model_step(input bit rst_i, input bit sw, input bit prq, input bit kick);
    bit timeout;
    if (!rst_i) begin
      r = S + 1 + H; pre = 0; wd = 0; fired = 1'b0;
    end else if (r > 0) begin
      if (r <= H && sw) r = H;
      else              r = r - 1;
      if (r == 0) wd = 0;
    end else if (pre > 0) begin
      if (sw) begin
        r = H; pre = 0;
      end else begin
        pre = pre - 1;
        if (pre == 0) wd = 0;
      end
    end else begin
      timeout = WDOG_ON && !kick && (wd + 1 == W);
      if (sw || timeout) begin
        r = H;
        if (timeout) fired = 1'b1;
      end else if (prq) begin
        pre = P;
      end else if (kick) begin
        wd = 0;
      end else begin
        wd = wd + 1;
      end
    end
  endtask

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: rst_n/preset_n/ready/busy/wdog_fired got %b required %b",
               name, $time, got, exp);
    end
    n_cmp++;
    if (got.rst_n === 1'b0 && got.preset_n === 1'b0) begin
      n_fail++;
      $display("FAIL both_low t=%0t: RST_N_OUT=%b PRESET_N_OUT=%b required not both 0",
               $time, got.rst_n, got.preset_n);
    end
  endtask

  function automatic exp_t dut_out();
    return {RST_N_OUT, PRESET_N_OUT, READY, BUSY, WDOG_FIRED};
  endfunction

  // One clock cycle of stimulus; expectation for the following edge is queued.
  task automatic cyc(input bit rst_i, input bit sw, input bit prq, input bit kick);
    @(negedge CLK);
    RST = rst_i; SW_RST_REQ = sw; PRESET_REQ = prq; WDOG_KICK = kick;
    model_step(rst_i, sw, prq, kick);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // RST dropped between edges must reset the outputs with no clock edge.
  task automatic async_rst();
    exp_t rexp;
    @(negedge CLK);
    #2;
    RST = 1'b0; SW_RST_REQ = 1'b0; PRESET_REQ = 1'b0; WDOG_KICK = 1'b0;
    #1;
    rexp = '{rst_n: 1'b0, preset_n: 1'b1, ready: 1'b0, busy: 1'b1, fired: 1'b0};
    check("async_rst", dut_out(), rexp);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", dut_out(), e);
      end
    end
  end

  initial begin : stimulus
    exp_t rexp;
    #2 RST = 1'b0;
    #1;
    rexp = '{rst_n: 1'b0, preset_n: 1'b1, ready: 1'b0, busy: 1'b1, fired: 1'b0};
    check("power_on_reset", dut_out(), rexp);

    // Power-up: 3 cycles in reset, release, run past the edge-11 release.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(14);

    // Preset pulse, then combined request resolving as reset.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Reset aborting a preset on its 2nd cycle; preset request dropped in HOLD.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);

    // Async reset mid-HOLD and mid-PRESET.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    async_rst();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(14);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    async_rst();
    idle(14);

    // Regular kicks keep RUN alive; then silence lets the watchdog expire if built in.
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0, 1'b0, (i % 10) == 9);
    idle(45);
    async_rst();
    idle(14);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_rst();
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        cyc(1'b1, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
            $urandom_range(0, 11) == 0);
      end
    end

    @(posedge CLK);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
